bram_dma: RTL

//  Block-copy engine that acts as the initiator on one port of the dual-port bram.
//  On i_start it copies i_len words from i_src_addr to i_dst_addr.
//  The copy runs through a single bram port (write strobe, address, wdata out; rdata in).

---
 rtl/bram_dma_pkg.sv | 14 +
 rtl/bram_dma.sv | 118 +++++++++++
 2 files changed

// File: rtl/bram_dma_pkg.sv
// Shared types and constants for the bram block-copy engine.
package bram_dma_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } dma_state_t;

    localparam logic DIR_ASC  = 1'b0;
    localparam logic DIR_DESC = 1'b1;

endpackage

// File: rtl/bram_dma.sv
// Block-copy engine on one bram port: one read cycle then one write cycle per word,
// copying in whichever direction keeps overlapping source words intact.
module bram_dma
    import bram_dma_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned LEN_WIDTH  = 13
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_src_addr,
    input  logic [ADDR_WIDTH-1:0] i_dst_addr,
    input  logic [LEN_WIDTH-1:0]  i_len,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_mem_write,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_data,
    input  logic [DATA_WIDTH-1:0] i_mem_data
);

    localparam int unsigned EXT_WIDTH = ADDR_WIDTH + 1;

    dma_state_t            r_state;
    dma_state_t            w_state_next;
    logic [ADDR_WIDTH-1:0] r_src_ptr;
    logic [ADDR_WIDTH-1:0] r_dst_ptr;
    logic [ADDR_WIDTH-1:0] r_addr_hold;
    logic [DATA_WIDTH-1:0] r_data_hold;
    logic [LEN_WIDTH-1:0]  r_remaining;
    logic                  r_dir;

    logic [EXT_WIDTH-1:0]  w_src_ext;
    logic [EXT_WIDTH-1:0]  w_dst_ext;
    logic [EXT_WIDTH-1:0]  w_src_end;
    logic [ADDR_WIDTH-1:0] w_len_m1;
    logic                  w_dir;
    logic                  w_accept;

    // Destination inside (src, src+len) would clobber unread source words going up.
    assign w_src_ext = {1'b0, i_src_addr};
    assign w_dst_ext = {1'b0, i_dst_addr};
    assign w_src_end = w_src_ext + EXT_WIDTH'(i_len);
    assign w_len_m1  = ADDR_WIDTH'(i_len - LEN_WIDTH'(1));
    assign w_dir     = ((w_dst_ext > w_src_ext) && (w_dst_ext < w_src_end)) ? DIR_DESC : DIR_ASC;
    assign w_accept  = (r_state == IDLE) && i_start;

    always_comb begin
        w_state_next = r_state;
        o_busy       = 1'b1;
        o_done       = 1'b0;
        o_mem_write  = 1'b0;
        o_mem_addr   = r_addr_hold;
        o_mem_data   = r_data_hold;
        case (r_state)
            IDLE: begin
                o_busy = 1'b0;
                if (i_start) begin
                    w_state_next = (i_len == '0) ? DONE : RD;
                end
            end
            RD: begin
                o_mem_addr   = r_src_ptr;
                w_state_next = WR;
            end
            WR: begin
                o_mem_write  = 1'b1;
                o_mem_addr   = r_dst_ptr;
                o_mem_data   = i_mem_data;
                w_state_next = (r_remaining == LEN_WIDTH'(1)) ? DONE : RD;
            end
            DONE: begin
                o_done       = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_src_ptr   <= '0;
            r_dst_ptr   <= '0;
            r_addr_hold <= '0;
            r_data_hold <= '0;
            r_remaining <= '0;
            r_dir       <= DIR_ASC;
        end else begin
            r_state     <= w_state_next;
            r_addr_hold <= o_mem_addr;
            r_data_hold <= o_mem_data;
            if (w_accept) begin
                r_dir       <= w_dir;
                r_remaining <= i_len;
                if (w_dir == DIR_DESC) begin
                    r_src_ptr <= i_src_addr + w_len_m1;
                    r_dst_ptr <= i_dst_addr + w_len_m1;
                end else begin
                    r_src_ptr <= i_src_addr;
                    r_dst_ptr <= i_dst_addr;
                end
            end else if (r_state == WR) begin
                r_remaining <= r_remaining - LEN_WIDTH'(1);
                if (r_dir == DIR_DESC) begin
                    r_src_ptr <= r_src_ptr - ADDR_WIDTH'(1);
                    r_dst_ptr <= r_dst_ptr - ADDR_WIDTH'(1);
                end else begin
                    r_src_ptr <= r_src_ptr + ADDR_WIDTH'(1);
                    r_dst_ptr <= r_dst_ptr + ADDR_WIDTH'(1);
                end
            end
        end
    end

endmodule
